// File: rtl/exec_sequencer.sv
// Run-control sequencer: owns the PC, fetches from program ROM and issues
// instructions over valid/ready with run / step / breakpoint / halt / restart.
module exec_sequencer #(
  parameter int                 ADDR_W     = 3,
  parameter int                 INSTR_W    = 8,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 8'hFF,
  parameter int                 CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               step_req,
  input  logic               restart,
  input  logic               bp_en,
  input  logic [ADDR_W-1:0]  bp_addr,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               issue_valid,
  output logic [INSTR_W-1:0] issue_instr,
  input  logic               issue_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               paused,
  output logic               halted,
  output logic               bp_hit,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [1:0] {S_PAUSED, S_FETCH, S_ISSUE, S_HALTED} state_t;

  state_t            state, state_nx;
  logic              single, single_nx;
  logic              advance, bp_set;
  logic [ADDR_W-1:0] pc_inc;

  assign rom_addr = pc;
  assign pc_inc   = pc + 1'b1;

  always_comb begin
    state_nx  = state;
    single_nx = single;
    advance   = 1'b0;
    bp_set    = 1'b0;
    if (restart) begin
      state_nx  = S_PAUSED;
      single_nx = 1'b0;
    end else begin
      case (state)
        S_PAUSED: begin
          if (run) begin
            state_nx = S_FETCH;
          end else if (step_req) begin
            state_nx  = S_FETCH;
            single_nx = 1'b1;
          end
        end
        // no breakpoint check here so a resumed breakpoint always executes
        S_FETCH: state_nx = (rom_data == HALT_INSTR) ? S_HALTED : S_ISSUE;
        S_ISSUE: begin
          if (issue_ready) begin
            advance = 1'b1;
            if (single) begin
              state_nx  = S_PAUSED;
              single_nx = 1'b0;
            end else if (!run) begin
              state_nx = S_PAUSED;
            end else if (bp_en && pc_inc == bp_addr) begin
              state_nx = S_PAUSED;
              bp_set   = 1'b1;
            end else begin
              state_nx = S_FETCH;
            end
          end
        end
        default: state_nx = S_HALTED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_PAUSED;
      single <= 1'b0;
    end else begin
      state  <= state_nx;
      single <= single_nx;
    end
  end

  // status outputs are registered from the next state so they track state exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      retired     <= '0;
      issue_valid <= 1'b0;
      issue_instr <= '0;
      paused      <= 1'b1;
      halted      <= 1'b0;
      bp_hit      <= 1'b0;
    end else begin
      issue_valid <= (state_nx == S_ISSUE);
      paused      <= (state_nx == S_PAUSED);
      halted      <= (state_nx == S_HALTED);
      if (state == S_FETCH && !restart)
        issue_instr <= rom_data;
      if (restart) begin
        pc      <= '0;
        retired <= '0;
      end else if (advance) begin
        pc <= pc_inc;
        if (retired != {CNT_W{1'b1}})
          retired <= retired + 1'b1;
      end
      if (restart)
        bp_hit <= 1'b0;
      else if (bp_set)
        bp_hit <= 1'b1;
      else if (state == S_PAUSED && state_nx != S_PAUSED)
        bp_hit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: cycle table for free-run, then
// hand-written step / breakpoint / stall / restart / wrap / reset sequences.
module tb_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, run, step_req, restart, bp_en, issue_ready;
  logic [2:0] bp_addr, rom_addr, pc;
  logic [7:0] rom_data, issue_instr, retired;
  logic       issue_valid, paused, halted, bp_hit;
  logic [7:0] rom [8];

  int tests = 0;
  int fails = 0;
  logic [7:0] acc_q [$];
  logic       ff_issued = 1'b0;

  exec_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step_req(step_req), .restart(restart),
    .bp_en(bp_en), .bp_addr(bp_addr), .rom_addr(rom_addr), .rom_data(rom_data),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_ready(issue_ready),
    .pc(pc), .paused(paused), .halted(halted), .bp_hit(bp_hit), .retired(retired)
  );

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  // accepted-instruction log, sampled mid-cycle when handshake inputs are stable
  always @(negedge clk) begin
    if (rst_n && issue_valid && issue_ready && !restart) acc_q.push_back(issue_instr);
    if (rst_n && issue_valid && issue_instr == 8'hFF) ff_issued = 1'b1;
  end

  typedef struct {
    logic       run, rdy;
    logic       iv;
    logic [7:0] instr;
    logic [2:0] pc;
    logic       paused, halted;
    logic [7:0] ret;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(logic r, logic iv, logic [7:0] ins, logic [2:0] p,
                              logic pa, logic h, logic [7:0] rt);
    vec_t v;
    v.run = r; v.rdy = 1'b1; v.iv = iv; v.instr = ins; v.pc = p;
    v.paused = pa; v.halted = h; v.ret = rt;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] packq();
    logic [63:0] r = '0;
    foreach (acc_q[i]) r = {r[55:0], acc_q[i]};
    return r;
  endfunction

  task automatic pulse_restart();
    restart = 1'b1; tick(); restart = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run = 0; step_req = 0; restart = 0; bp_en = 0; bp_addr = 0;
    issue_ready = 1'b1;
    rom[0] = 8'h01; rom[1] = 8'h02; rom[2] = 8'h03; rom[3] = 8'h04;
    rom[4] = 8'h05; rom[5] = 8'hFF; rom[6] = 8'h07; rom[7] = 8'h08;

    tbl[0]  = mk(1, 0, 8'h00, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 8'h01, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 8'h00, 1, 0, 0, 1);
    tbl[3]  = mk(1, 1, 8'h02, 1, 0, 0, 1);
    tbl[4]  = mk(1, 0, 8'h00, 2, 0, 0, 2);
    tbl[5]  = mk(1, 1, 8'h03, 2, 0, 0, 2);
    tbl[6]  = mk(1, 0, 8'h00, 3, 0, 0, 3);
    tbl[7]  = mk(1, 1, 8'h04, 3, 0, 0, 3);
    tbl[8]  = mk(1, 0, 8'h00, 4, 0, 0, 4);
    tbl[9]  = mk(1, 1, 8'h05, 4, 0, 0, 4);
    tbl[10] = mk(1, 0, 8'h00, 5, 0, 0, 5);
    tbl[11] = mk(1, 0, 8'h00, 5, 0, 1, 5);
    tbl[12] = mk(0, 0, 8'h00, 5, 0, 1, 5);

    #12 rst_n = 1'b1;
    #1;
    chk("reset", {issue_valid, issue_instr, pc, paused, halted, bp_hit, retired},
        {1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00});

    // free run to halt, cycle by cycle
    for (int i = 0; i < 13; i++) begin
      run = tbl[i].run; issue_ready = tbl[i].rdy;
      tick();
      chk($sformatf("run_vec%0d", i),
          {issue_valid, issue_valid ? issue_instr : 8'h00, pc, paused, halted, retired},
          {tbl[i].iv, tbl[i].instr, tbl[i].pc, tbl[i].paused, tbl[i].halted, tbl[i].ret});
    end
    chk("run_accepted", packq(), 64'h0102030405);
    chk("halt_never_issued", {63'd0, ff_issued}, 64'd0);

    // HALTED ignores run/step, restart exits
    run = 1; step_req = 1; tick(); step_req = 0; run = 0;
    chk("halted_sticky", {halted, pc}, {1'b1, 3'd5});
    pulse_restart(); #0;
    chk("restart_from_halt", {paused, halted, pc, retired}, {1'b1, 1'b0, 3'd0, 8'd0});

    // single step, three pulses
    acc_q.delete();
    for (int k = 1; k <= 3; k++) begin
      step_req = 1; tick(); step_req = 0;
      repeat (5) tick();
      chk($sformatf("step%0d", k), {paused, pc, retired}, {1'b1, 3'(k), 8'(k)});
    end
    chk("step_accepted", packq(), 64'h010203);

    // breakpoint at 3
    pulse_restart(); acc_q.delete();
    bp_en = 1; bp_addr = 3'd3; run = 1;
    for (int i = 0; i < 60 && !(paused && bp_hit); i++) tick();
    run = 0;
    chk("bp_stop", {paused, bp_hit, pc, retired}, {1'b1, 1'b1, 3'd3, 8'd3});
    chk("bp_accepted", packq(), 64'h010203);
    tick();
    chk("bp_held", {paused, bp_hit}, {1'b1, 1'b1});
    run = 1; tick();
    chk("bp_resume", {paused, bp_hit}, {1'b0, 1'b0});
    for (int i = 0; i < 60 && !halted; i++) tick();
    chk("bp_to_halt", {halted, pc, retired}, {1'b1, 3'd5, 8'd5});
    chk("bp_all_accepted", packq(), 64'h0102030405);
    run = 0; bp_en = 0;

    // stall in ISSUE; run dropping does not withdraw the offer
    pulse_restart();
    run = 1; issue_ready = 0;
    tick(); tick();
    run = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall%0d", i), {issue_valid, issue_instr, pc}, {1'b1, 8'h01, 3'd0});
    end
    issue_ready = 1; tick();
    chk("stall_accept", {pc, retired, issue_valid, paused}, {3'd1, 8'd1, 1'b0, 1'b1});

    // restart beats a simultaneous handshake
    run = 1; tick(); tick();
    chk("pre_restart_issue", {issue_valid, issue_instr, pc}, {1'b1, 8'h02, 3'd1});
    restart = 1; run = 0; tick(); restart = 0;
    chk("restart_vs_hs", {pc, retired, paused, issue_valid}, {3'd0, 8'd0, 1'b1, 1'b0});

    // wrap and saturation with no halt in ROM
    for (int i = 0; i < 8; i++) rom[i] = 8'h11;
    run = 1; issue_ready = 1;
    repeat (41) tick();
    chk("wrap20", {pc, retired}, {3'd4, 8'd20});
    repeat (560) tick();
    chk("saturate300", {pc, retired}, {3'd4, 8'hFF});

    // async reset while offering
    issue_ready = 0;
    for (int i = 0; i < 4 && !issue_valid; i++) tick();
    chk("pre_reset_issue", {issue_valid, pc}, {1'b1, 3'd4});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {issue_valid, issue_instr, pc, paused, halted, bp_hit, retired},
        {1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00});
    run = 0;
    #10 rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Run-control sequencer between the processor and program_rom.
- Owns the program counter, fetches instructions from the ROM and issues them to the processor over a valid/ready handshake.
- Supports free-run, single-step, a PC breakpoint, a halt instruction and restart, so the 8-instruction machine can be driven and debugged from board inputs.

Parameters:
ADDR_W, 3, program address width (ROM depth 2^ADDR_W)
INSTR_W, 8, instruction width
HALT_INSTR, 8'hFF, instruction encoding that stops execution (never issued)
CNT_W, 8, retired-instruction counter width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; continuous execution while high
step_req  in  1  one-cycle pulse; execute exactly one instruction from PAUSED
restart  in  1  one-cycle pulse; pc and counter to 0, go to PAUSED
bp_en  in  1  breakpoint enable
bp_addr  in  ADDR_W  breakpoint PC
rom_addr  out  ADDR_W  ROM address, combinationally equal to pc
rom_data  in  INSTR_W  ROM instruction, combinational, valid same cycle
issue_valid  out  1  instruction offered to processor
issue_instr  out  INSTR_W  instruction offered, stable while issue_valid
issue_ready  in  1  processor accepts when issue_valid && issue_ready
pc  out  ADDR_W  current program counter
paused  out  1  high in PAUSED
halted  out  1  high in HALTED
bp_hit  out  1  sticky; set on breakpoint stop, cleared on leaving PAUSED
retired  out  CNT_W  accepted-instruction count, saturating

Behaviour:
- Single clock domain. rst_n is asynchronous active-low.
- Reset values: state=PAUSED, pc=0, issue_valid=0, issue_instr=0, paused=1, halted=0, bp_hit=0, retired=0, single flag=0.
- All outputs are registered except rom_addr, which is wired to pc.
- States are PAUSED, FETCH, ISSUE, HALTED.
- PAUSED:
  - If run is high, go to FETCH.
  - Else if step_req is high, go to FETCH and set single=1.
  - run takes priority over step_req.
  - bp_hit clears on exit.
- FETCH (one cycle):
  - Register rom_data into instr_q.
  - If rom_data==HALT_INSTR, go to HALTED; pc is unchanged and nothing is issued.
  - Otherwise go to ISSUE.
  - No breakpoint check here, so resuming from a breakpoint always executes the breakpointed instruction.
- ISSUE:
  - issue_valid=1 and issue_instr=instr_q, held until handshake. Indefinite stall on issue_ready=0 is legal.
  - On handshake: pc<=pc+1 with wrap (7 -> 0, no flag); retired<=retired+1, saturating at all-ones.
  - Next state on handshake, in priority order:
    1. single=1: go to PAUSED, clear single.
    2. run=0: go to PAUSED.
    3. bp_en && (pc+1)==bp_addr: go to PAUSED, set bp_hit=1.
    4. Otherwise go to FETCH.
  - issue_valid deasserts the cycle after handshake.
  - run dropping while stalled in ISSUE does not withdraw issue_valid; the offered instruction completes first.
- HALTED:
  - Stays there. run and step_req are ignored.
  - Only restart or rst_n exits.
- restart:
  - Wins over every other event in any state: pc<=0, retired<=0, bp_hit<=0, single<=0, issue_valid<=0, go to PAUSED.
  - A handshake in the same cycle as restart is not counted and does not advance pc.
- Latency and throughput:
  - run rising in PAUSED gives FETCH on the next cycle and issue_valid the cycle after.
  - Sustained throughput is 1 instruction per 2 cycles with issue_ready held high.
- A breakpoint at an address never reached has no effect. bp_addr changes take effect on the next handshake comparison.

Test Plan:
- ROM[0..7]=01,02,03,04,05,FF,07,08; reset, run=1, issue_ready=1 -> issue_instr 01..05 accepted on alternate cycles; halted=1 with pc=5; retired=5; FF never has issue_valid.
- Same ROM, run=0; pulse step_req three times, spaced 6 cycles apart -> exactly one issue per pulse (01, 02, 03); paused=1 between pulses; pc=3; retired=3.
- bp_en=1, bp_addr=3, run=1 -> 01,02,03 accepted, then PAUSED with bp_hit=1 and pc=3; toggle run 0->1 -> bp_hit clears, 04 issues next, run continues to halt.
- issue_ready=0 for 5 cycles during first ISSUE -> issue_valid=1 and issue_instr=01 held stable; pc stays 0; accepted on the cycle ready rises, pc becomes 1.
- ROM all 11 (no halt), run=1 for 20 handshakes -> pc wraps 7 -> 0 and reads 4 after 20 handshakes; retired=20. Separately preload the count near saturation -> retired stays at 255.
- From HALTED pulse restart -> PAUSED, pc=0, retired=0, halted=0; assert rst_n=0 mid-ISSUE -> issue_valid drops immediately (asynchronously), all outputs at reset values.
